// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: N-digit BCD up/down stopwatch with prescaled tick, start/stop and clear.
// Define BCD_STOPWATCH_LAP_EN to add a lap input that freezes the displayed value.
module bcd_stopwatch #(
  parameter int N_DIGITS = 2,
  parameter int DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  up_down,
`ifdef BCD_STOPWATCH_LAP_EN
  input  logic                  lap,
`endif
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  running,
  output logic                  wrap
);
  localparam int PW = $clog2(DIV);
  typedef enum logic {STOP, RUN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4*N_DIGITS-1:0] cnt_q, cnt_d;
  logic wrap_q, wrap_d, tick, carry;
  assign tick = state_q == RUN && presc_q == PW'(DIV - 1);
  always_comb begin
    state_d = start_stop ? state_t'(~state_q) : state_q;
    presc_d = clear || tick ? '0 : state_q == RUN ? presc_q + PW'(1) : presc_q;
    cnt_d = cnt_q;
    carry = tick;
    // ripple carry/borrow: a digit moves only when every lower digit rolled over
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry)
        cnt_d[4*i +: 4] = up_down ? (cnt_q[4*i +: 4] == 4'd9 ? 4'd0 : cnt_q[4*i +: 4] + 4'd1)
                                  : (cnt_q[4*i +: 4] == 4'd0 ? 4'd9 : cnt_q[4*i +: 4] - 4'd1);
      carry = carry && cnt_q[4*i +: 4] == (up_down ? 4'd9 : 4'd0);
    end
    wrap_d = carry && !clear;
    if (clear) cnt_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= STOP;
      presc_q <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  assign running = state_q == RUN;
  assign wrap = wrap_q;
`ifdef BCD_STOPWATCH_LAP_EN
  logic frozen_q, frozen_d;
  logic [4*N_DIGITS-1:0] snap_q, snap_d;
  always_comb begin
    frozen_d = clear ? 1'b0 : lap && state_q == RUN ? ~frozen_q : frozen_q;
    snap_d = !frozen_q && frozen_d ? cnt_q : snap_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
    end
  assign bcd = frozen_q ? snap_q : cnt_q;
`else
  assign bcd = cnt_q;
`endif
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: queued expectations from a decimal reference model plus hand-computed checkpoints.
module tb_bcd_stopwatch;
  localparam int DIV = 4;
  typedef struct {
    logic [7:0] b;
    logic r, w;
    bit h;
    logic [7:0] hb;
    logic hr, hw;
    int cyc;
  } ent_t;
  logic clk = 1'b0, rst_n = 1'b0, start_stop = 1'b0, clear = 1'b0, up_down = 1'b1, lap = 1'b0;
  logic [7:0] bcd;
  logic running, wrap;
  ent_t exp_q[$];
  int total = 0, bad = 0, scyc = 0;
  int m_cnt = 0, m_presc = 0, m_snap = 0;
  bit m_run = 0, m_wrap = 0, m_frz = 0, ud_g = 1;

  always #5 clk = ~clk;

  bcd_stopwatch #(.N_DIGITS(2), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .up_down(up_down),
`ifdef BCD_STOPWATCH_LAP_EN
    .lap(lap),
`endif
    .bcd(bcd), .running(running), .wrap(wrap)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  task automatic step(input bit rs, input bit ss, input bit cl, input bit ud, input bit lp);
    ent_t e;
    bit tick, nfrz;
    @(negedge clk);
    rst_n = rs; start_stop = ss; clear = cl; up_down = ud; lap = lp;
    if (!rs) begin
      m_run = 0; m_presc = 0; m_cnt = 0; m_wrap = 0; m_frz = 0;
    end else begin
      tick = m_run && m_presc == DIV - 1;
      nfrz = cl ? 1'b0 : (lp && m_run) ? !m_frz : m_frz;
      if (!m_frz && nfrz) m_snap = m_cnt;
      m_frz = nfrz;
      m_wrap = 0;
      if (cl) begin
        m_cnt = 0; m_presc = 0;
      end else if (tick) begin
        m_presc = 0;
        if (ud) begin m_wrap = m_cnt == 99; m_cnt = (m_cnt + 1) % 100; end
        else begin m_wrap = m_cnt == 0; m_cnt = (m_cnt + 99) % 100; end
      end else if (m_run) m_presc++;
      if (ss) m_run = !m_run;
    end
    scyc++;
    e = '{b: to_bcd(m_frz ? m_snap : m_cnt), r: m_run, w: m_wrap, h: 0, hb: 8'h00, hr: 0, hw: 0, cyc: scyc};
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, ud_g, 0);
  endtask

  // attach a hand-computed expectation to the cycle just issued
  task automatic hand(input logic [7:0] b, input logic r, input logic w);
    ent_t e;
    e = exp_q.pop_back();
    e.h = 1; e.hb = b; e.hr = r; e.hw = w;
    exp_q.push_back(e);
  endtask

  initial forever begin
    ent_t e;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({bcd, running, wrap} !== {e.b, e.r, e.w}) begin
        bad++;
        $display("FAIL model cyc=%0d got bcd=%h run=%b wrap=%b want bcd=%h run=%b wrap=%b",
                 e.cyc, bcd, running, wrap, e.b, e.r, e.w);
      end
      if (e.h) begin
        total++;
        if ({bcd, running, wrap} !== {e.hb, e.hr, e.hw}) begin
          bad++;
          $display("FAIL hand cyc=%0d got bcd=%h run=%b wrap=%b want bcd=%h run=%b wrap=%b",
                   e.cyc, bcd, running, wrap, e.hb, e.hr, e.hw);
        end
      end
    end
  end

  initial begin
    repeat (3) step(0, 0, 0, 1, 0);
    hand(8'h00, 0, 0);
    idle(10);
    hand(8'h00, 0, 0);
    ud_g = 1;
    step(1, 1, 0, 1, 0);
    hand(8'h00, 1, 0);
    idle(4);
    hand(8'h01, 1, 0);
    idle(36);
    hand(8'h10, 1, 0);
    idle(356);
    hand(8'h99, 1, 0);
    idle(4);
    hand(8'h00, 1, 1);
    idle(1);
    hand(8'h00, 1, 0);
    ud_g = 0;
    idle(2);
    hand(8'h00, 1, 0);
    idle(1);
    hand(8'h99, 1, 1);
    idle(1);
    hand(8'h99, 1, 0);
    step(1, 0, 1, 0, 0);
    hand(8'h00, 1, 0);
    ud_g = 1;
    idle(20);
    hand(8'h05, 1, 0);
    idle(2);
    step(1, 1, 0, 1, 0);
    hand(8'h05, 0, 0);
    idle(20);
    hand(8'h05, 0, 0);
    step(1, 1, 0, 1, 0);
    hand(8'h05, 1, 0);
    idle(1);
    hand(8'h06, 1, 0);
    idle(124);
    hand(8'h37, 1, 0);
    idle(3);
    hand(8'h37, 1, 0);
    step(1, 0, 1, 1, 0);
    hand(8'h00, 1, 0);
    step(1, 1, 1, 1, 0);
    hand(8'h00, 0, 0);
    idle(5);
    hand(8'h00, 0, 0);
    step(1, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, i[2], 0);
    hand(8'h00, 1, 1);
    idle(6);
    step(0, 0, 0, 1, 0);
    hand(8'h00, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(3);
    hand(8'h00, 0, 0);
`ifdef BCD_STOPWATCH_LAP_EN
    step(1, 1, 0, 1, 0);
    idle(48);
    hand(8'h12, 1, 0);
    step(1, 0, 0, 1, 1);
    hand(8'h12, 1, 0);
    idle(39);
    hand(8'h12, 1, 0);
    step(1, 0, 0, 1, 1);
    hand(8'h22, 1, 0);
    idle(3);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 1);
    idle(8);
    hand(8'h23, 0, 0);
    step(1, 1, 0, 1, 0);
    idle(4);
    step(1, 0, 0, 1, 1);
    step(1, 0, 1, 1, 0);
    hand(8'h00, 1, 0);
    idle(6);
`endif
    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
